// File: rtl/issue_scoreboard_if.sv
// ---------------------------------------------------------------------------
// issue_scoreboard_if
//
// Purpose: bundles the issue handshake from decode/pc_gen and the
// calculation-unit writeback bus observed by the issue scoreboard.
//
// Signals:
//   iss_valid   decode presents an instruction
//   iss_ready   scoreboard accepts the instruction this cycle
//   iss_rs1_ad  source 1 address,       iss_rs1_v  source 1 is read
//   iss_rs2_ad  source 2 address,       iss_rs2_v  source 2 is read
//   iss_rd_ad   destination address,    iss_rd_v   instruction writes rd
//   res_v       writeback valid,        res_adr    writeback register address
//
// Modports:
//   master  driven by the decode / writeback side
//   slave   used by the scoreboard
// ---------------------------------------------------------------------------
interface issue_scoreboard_if;
    logic       iss_valid;
    logic       iss_ready;
    logic [4:0] iss_rs1_ad;
    logic       iss_rs1_v;
    logic [4:0] iss_rs2_ad;
    logic       iss_rs2_v;
    logic [4:0] iss_rd_ad;
    logic       iss_rd_v;
    logic       res_v;
    logic [4:0] res_adr;

    modport master (
        output iss_valid, iss_rs1_ad, iss_rs1_v, iss_rs2_ad, iss_rs2_v,
               iss_rd_ad, iss_rd_v, res_v, res_adr,
        input  iss_ready
    );

    modport slave (
        input  iss_valid, iss_rs1_ad, iss_rs1_v, iss_rs2_ad, iss_rs2_v,
               iss_rd_ad, iss_rd_v, res_v, res_adr,
        output iss_ready
    );
endinterface

// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//
// Purpose: hazard controller in front of the register-read stage. Keeps one
// busy bit per architectural register with a result in flight, stalls issue
// on RAW / WAW hazards or when the in-flight write limit is reached, and
// provides a drain sequence (RUN -> DRAIN -> HOLD) for quiescing issue.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   bus            issue handshake + writeback bus (issue_scoreboard_if.slave)
//   drain_req      request to quiesce issue
//   drained_o      no writes outstanding while drain is active (registered)
//   inflight_o     outstanding register write count
//   busy_o         busy bit vector, register 0 never busy
//   stall_cause_o  {limit, waw, raw}, zero unless a valid issue is stalled
//
// Configuration:
//   SCOREBOARD_BYPASS_EN  when defined, a register being cleared by the
//                         writeback bus in the same cycle counts as not busy
//                         for hazards, and that writeback relieves the limit.
// ---------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int xlen         = 32,
    parameter int NREG         = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    issue_scoreboard_if.slave                     bus,
    input  logic                                  drain_req,
    output logic                                  drained_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_o,
    output logic [NREG-1:0]                       busy_o,
    output logic [2:0]                            stall_cause_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    // Reject configurations the counter and busy vector cannot represent.
    if (xlen < 1 || MAX_INFLIGHT < 1 || MAX_INFLIGHT > NREG - 1) begin : g_bad_cfg
        $error("issue_scoreboard: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [NREG-1:0] busy;
    logic [CW-1:0]   inflight;

    logic [NREG-1:0] busy_view;
    logic            wb_clear;
    logic            raw;
    logic            waw;
    logic            limit;
    logic            ready;
    logic            set_busy;
    logic [NREG-1:0] busy_next;

    // A writeback only counts when it retires a register that is actually
    // busy; writebacks to idle registers or register 0 are ignored so the
    // counter can never underflow.
    always_comb begin
        wb_clear = bus.res_v && (bus.res_adr != 5'd0) && busy[bus.res_adr];
    end

    // Hazard view of the busy bits. With the bypass, the register being
    // retired this cycle already looks free to the issuing instruction.
    always_comb begin
        busy_view = busy;
`ifdef SCOREBOARD_BYPASS_EN
        if (wb_clear) begin
            busy_view[bus.res_adr] = 1'b0;
        end
`endif
    end

    // Hazard detection and the ready decision. Register 0 is never set busy,
    // so it cannot raise raw/waw; the limit only applies to real writes.
    // Ready deliberately ignores iss_valid.
    always_comb begin
        raw   = (bus.iss_rs1_v && busy_view[bus.iss_rs1_ad]) ||
                (bus.iss_rs2_v && busy_view[bus.iss_rs2_ad]);
        waw   = bus.iss_rd_v && busy_view[bus.iss_rd_ad];
`ifdef SCOREBOARD_BYPASS_EN
        limit = bus.iss_rd_v && (bus.iss_rd_ad != 5'd0) &&
                (inflight == MAX_CNT) && !wb_clear;
`else
        limit = bus.iss_rd_v && (bus.iss_rd_ad != 5'd0) &&
                (inflight == MAX_CNT);
`endif
        ready = (state == RUN) && !drain_req && !raw && !waw && !limit;
        set_busy = bus.iss_valid && ready && bus.iss_rd_v &&
                   (bus.iss_rd_ad != 5'd0);
        stall_cause_o = (bus.iss_valid && !ready) ? {limit, waw, raw} : 3'b000;
    end

    // Next busy vector: clear the retired register first, then set the newly
    // issued destination so a same-register bypass keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (wb_clear) begin
            busy_next[bus.res_adr] = 1'b0;
        end
        if (set_busy) begin
            busy_next[bus.iss_rd_ad] = 1'b1;
        end
    end

    // Busy bits and in-flight counter. A simultaneous issue and retire leave
    // the count unchanged; the bounds guards keep it within 0..MAX_INFLIGHT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            inflight <= '0;
        end else begin
            busy <= busy_next;
            if (set_busy && !wb_clear && inflight != MAX_CNT) begin
                inflight <= inflight + 1'b1;
            end else if (wb_clear && !set_busy && inflight != '0) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    // Drain state machine with a registered drained flag. DRAIN waits for
    // the counter to reach zero, HOLD reports drained until the request
    // drops, and dropping the request mid-drain returns straight to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drained_o <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    drained_o <= 1'b0;
                    if (drain_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state     <= RUN;
                        drained_o <= 1'b0;
                    end else if (inflight == '0) begin
                        state     <= HOLD;
                        drained_o <= 1'b1;
                    end else begin
                        drained_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!drain_req) begin
                        state     <= RUN;
                        drained_o <= 1'b0;
                    end else begin
                        drained_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    drained_o <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        bus.iss_ready = ready;
        busy_o        = busy;
        inflight_o    = inflight;
    end

endmodule
